bpu_train_ctrl: RTL

Controller for the branch predictor's BHT write port and misprediction recovery. It accepts verify results from EX through a 4-entry training FIFO and computes updated 2-bit counters. It sequences the single BHT write port between a post-reset clear sweep and training writes. It runs the correction FSM that drives the fetch redirect once the delay slot has been fetched. It sits between EX, the BHT storage in IF and the fetch PC mux.

---
 rtl/bpu_train_if.sv | 37 +++
 rtl/bpu_train_ctrl.sv | 69 ++++++
 2 files changed

// File: rtl/bpu_train_if.sv
// bpu_train_if: EX verify / fetch redirect / BHT write bundle for the training controller
interface bpu_train_if #(parameter int IDX_W = 8, parameter int TAG_W = 21);
  logic flush_ex;
  logic upd_valid;
  logic upd_ready;
  logic [31:0] upd_pc;
  logic upd_taken;
  logic [31:0] upd_target;
  logic upd_success;
  logic [1:0] upd_count;
  logic [2:0] upd_br_type;
  logic mispredict_flush;
  logic redirect_valid;
  logic [31:0] redirect_target;
  logic redirect_ack;
  logic ds_done;
  logic bht_we;
  logic [IDX_W-1:0] bht_waddr;
  logic [TAG_W-1:0] bht_wtag;
  logic [31:0] bht_wtarget;
  logic [1:0] bht_wcount;
  logic [2:0] bht_wtype;
  logic init_busy;
  logic correcting;
  modport master (
    output flush_ex, upd_valid, upd_pc, upd_taken, upd_target, upd_success, upd_count, upd_br_type,
           redirect_ack, ds_done,
    input  upd_ready, mispredict_flush, redirect_valid, redirect_target,
           bht_we, bht_waddr, bht_wtag, bht_wtarget, bht_wcount, bht_wtype, init_busy, correcting
  );
  modport slave (
    input  flush_ex, upd_valid, upd_pc, upd_taken, upd_target, upd_success, upd_count, upd_br_type,
           redirect_ack, ds_done,
    output upd_ready, mispredict_flush, redirect_valid, redirect_target,
           bht_we, bht_waddr, bht_wtag, bht_wtarget, bht_wcount, bht_wtype, init_busy, correcting
  );
endinterface

// File: rtl/bpu_train_ctrl.sv
// bpu_train_ctrl: BHT clear sweep, training FIFO/write port and misprediction redirect FSM
module bpu_train_ctrl #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 21,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  bpu_train_if.slave bus
);
  localparam int EW = IDX_W + TAG_W + 37;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WAIT_DS = 2'd1, REDIRECT = 2'd2;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW:0] wp, rp;
  logic [IDX_W-1:0] sweep;
  logic busy;
  logic [1:0] state;
  logic [31:0] tgt;
  logic full, empty, accept, enq, deq, misp;
  logic [1:0] inc, dec, new_cnt;
  logic [EW-1:0] entry;
  assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign empty = wp == rp;
  assign bus.upd_ready = !busy && !full;
  assign accept = bus.upd_valid && bus.upd_ready;
  // updates arriving while a correction is pending are wrong-path and only consumed
  assign enq = accept && state == IDLE;
  assign deq = !busy && !empty;
  assign misp = enq && !bus.upd_success && !bus.flush_ex;
  assign bus.mispredict_flush = misp;
  assign inc = bus.upd_count == 2'b11 ? 2'b11 : bus.upd_count + 2'd1;
  assign dec = bus.upd_count == 2'b00 ? 2'b00 : bus.upd_count - 2'd1;
  assign new_cnt = bus.upd_success ? (bus.upd_taken ? inc : dec) : (bus.upd_taken ? 2'b10 : 2'b01);
  assign entry = {bus.upd_pc[IDX_W+1:2], bus.upd_pc[31:32-TAG_W], bus.upd_target, new_cnt, bus.upd_br_type};
  assign bus.bht_we = busy || !empty;
  assign {bus.bht_waddr, bus.bht_wtag, bus.bht_wtarget, bus.bht_wcount, bus.bht_wtype} =
    busy ? {sweep, {(EW-IDX_W){1'b0}}} : mem[rp[PW-1:0]];
  assign bus.init_busy = busy;
  assign bus.correcting = state != IDLE;
  assign bus.redirect_valid = state == REDIRECT;
  assign bus.redirect_target = tgt;
  always_ff @(posedge clk)
    if (enq && !reset) mem[wp[PW-1:0]] <= entry;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      sweep <= '0;
      busy <= 1'b1;
    end else begin
      if (enq) wp <= wp + 1'b1;
      if (deq) rp <= rp + 1'b1;
      if (busy) sweep <= sweep + 1'b1;
      if (busy && &sweep) busy <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || bus.flush_ex) begin
      state <= IDLE;
      tgt <= '0;
    end else begin
      state <= state == IDLE    ? (misp ? WAIT_DS : IDLE) :
               state == WAIT_DS ? (bus.ds_done ? REDIRECT : WAIT_DS) :
                                  (bus.redirect_ack ? IDLE : REDIRECT);
      if (misp) tgt <= bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd8;
    end
  end
endmodule
